i2s_frame_tx: RTL and testbench

I2S frame transmitter: the master-side counterpart of the splitstreamer I2S input. Takes parallel stereo sample pairs over a valid/ready handshake and serialises them MSB-first onto generated bit-clock, frame-clock and data lines. Used as the I2S source in loopback benches and as the I2S output stage of the board design. Runs entirely in the PLL clock domain.

---
 rtl/i2s_frame_tx_if.sv | 24 ++
 rtl/i2s_frame_tx.sv | 112 +++++++++++
 tb/tb_i2s_frame_tx.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_frame_tx_if.sv
// Sample-pair handshake between a stereo sample source and the I2S frame transmitter.
// The master offers a left/right pair with sample_valid; the slave accepts it with sample_ready.
interface i2s_frame_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] left_data;
    logic [WIDTH-1:0] right_data;
    logic             sample_valid;
    logic             sample_ready;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_frame_tx.sv
// I2S master transmitter: buffers one stereo pair and shifts it out MSB-first,
// left-justified, with generated bit clock and frame clock.
module i2s_frame_tx #(
    parameter int WIDTH    = 32,
    parameter int BCLK_DIV = 1
) (
    input  logic           pin_i2s_bclk_pll,
    input  logic           rst,
    i2s_frame_tx_if.slave  smp,
    output logic           i2s_bclk,
    output logic           i2s_fclk,
    output logic           i2s_data,
    output logic           frame_start,
    output logic           underrun
);
    localparam int FRAME_BITS = 2 * WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] SLOT_BITS = CNT_W'(WIDTH);

    logic [DIV_W-1:0]      div_cnt_r;
    logic                  bclk_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [FRAME_BITS-1:0] shift_r;
    logic                  fclk_r;
    logic                  frame_start_r;
    logic                  underrun_r;
    logic [FRAME_BITS-1:0] buf_r;
    logic                  buf_full_r;

    logic                  div_tc_s;
    logic                  fall_s;
    logic [CNT_W-1:0]      bit_next_s;
    logic                  boundary_s;
    logic                  xfer_s;

    // Divider terminal count, falling-edge event, next bit index and handshake decode
    always_comb begin
        div_tc_s   = 1'b0;
        fall_s     = 1'b0;
        bit_next_s = {CNT_W{1'b0}};
        boundary_s = 1'b0;
        xfer_s     = 1'b0;
        div_tc_s   = (div_cnt_r == DIV_LAST);
        fall_s     = div_tc_s && bclk_r;
        if (bit_cnt_r == BIT_LAST) begin
            bit_next_s = {CNT_W{1'b0}};
        end else begin
            bit_next_s = bit_cnt_r + CNT_W'(1);
        end
        boundary_s = fall_s && (bit_next_s == {CNT_W{1'b0}});
        xfer_s     = smp.sample_valid && !buf_full_r;
    end

    // Bit-clock divider
    always_ff @(posedge pin_i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= 1'b0;
        end else if (div_tc_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            bclk_r    <= ~bclk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

    // Frame sequencer: all serial outputs move only on bclk falling edges
    always_ff @(posedge pin_i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            bit_cnt_r     <= BIT_LAST;
            shift_r       <= {FRAME_BITS{1'b0}};
            fclk_r        <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            frame_start_r <= boundary_s;
            underrun_r    <= boundary_s && !buf_full_r;
            if (fall_s) begin
                bit_cnt_r <= bit_next_s;
                fclk_r    <= (bit_next_s >= SLOT_BITS);
                if (boundary_s) begin
                    shift_r <= buf_full_r ? buf_r : {FRAME_BITS{1'b0}};
                end else begin
                    shift_r <= {shift_r[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    // Holding buffer; a load in the same clock as a transfer sees it empty (no bypass)
    always_ff @(posedge pin_i2s_bclk_pll or posedge rst) begin
        if (rst) begin
            buf_r      <= {FRAME_BITS{1'b0}};
            buf_full_r <= 1'b0;
        end else if (xfer_s) begin
            buf_r      <= {smp.left_data, smp.right_data};
            buf_full_r <= 1'b1;
        end else if (boundary_s) begin
            buf_full_r <= 1'b0;
        end
    end

    assign smp.sample_ready = ~buf_full_r;
    assign i2s_bclk         = bclk_r;
    assign i2s_fclk         = fclk_r;
    assign i2s_data         = shift_r[FRAME_BITS-1];
    assign frame_start      = frame_start_r;
    assign underrun         = underrun_r;
endmodule

// File: tb/tb_i2s_frame_tx.sv
// Bench for i2s_frame_tx: a time-indexed frame model predicts every output each cycle,
// plus a serial receiver recovering pairs, for BCLK_DIV=1 and BCLK_DIV=4 instances.
module tb_i2s_frame_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic [31:0] left  = 32'h0;
    logic [31:0] right = 32'h0;
    logic        valid = 1'b0;

    i2s_frame_tx_if #(.WIDTH(32)) ifa ();
    i2s_frame_tx_if #(.WIDTH(32)) ifb ();
    assign ifa.left_data    = left;
    assign ifa.right_data   = right;
    assign ifa.sample_valid = valid;
    assign ifb.left_data    = left;
    assign ifb.right_data   = right;
    assign ifb.sample_valid = valid;

    logic a_bclk, a_fclk, a_data, a_fs, a_ur;
    logic b_bclk, b_fclk, b_data, b_fs, b_ur;

    i2s_frame_tx #(.WIDTH(32), .BCLK_DIV(1)) dut_a (
        .pin_i2s_bclk_pll(clk), .rst(rst_a), .smp(ifa),
        .i2s_bclk(a_bclk), .i2s_fclk(a_fclk), .i2s_data(a_data),
        .frame_start(a_fs), .underrun(a_ur));

    i2s_frame_tx #(.WIDTH(32), .BCLK_DIV(4)) dut_b (
        .pin_i2s_bclk_pll(clk), .rst(rst_b), .smp(ifb),
        .i2s_bclk(b_bclk), .i2s_fclk(b_fclk), .i2s_data(b_data),
        .frame_start(b_fs), .underrun(b_ur));

    int  sel = 0;
    wire o_bclk = (sel != 0) ? b_bclk : a_bclk;
    wire o_fclk = (sel != 0) ? b_fclk : a_fclk;
    wire o_data = (sel != 0) ? b_data : a_data;
    wire o_fs   = (sel != 0) ? b_fs   : a_fs;
    wire o_ur   = (sel != 0) ? b_ur   : a_ur;
    wire o_rdy  = (sel != 0) ? ifb.sample_ready : ifa.sample_ready;

    int checks = 0;
    int failures = 0;

    // reference model: k = clock edges since reset release, frames indexed from first boundary
    int          k;
    logic [63:0] pend;
    bit          pend_full;
    logic [63:0] fw[$];
    bit          fur[$];
    logic [63:0] acc_q[$];
    logic [63:0] rx_q[$];
    logic [63:0] rx;
    int          rx_n;
    bit          rx_on, rx_ur;
    logic        prev_bclk;
    bit          rand_data = 1'b0;

    int          n, r1, r2, fs_cnt, ur_cnt, rises, last_rise, base;
    bit          found;
    logic        prev_rdy, prev_b;
    logic [63:0] pair;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cur_rst();
        return (sel != 0) ? rst_b : rst_a;
    endfunction

    task automatic model_reset();
        k = 0;
        pend = 64'h0;
        pend_full = 1'b0;
        fw.delete();
        fur.delete();
        rx_on = 1'b0;
        rx_n = 0;
        prev_bclk = 1'b0;
    endtask

    task automatic model_edge();
        int  d;
        bit  rdy_before;
        d = (sel != 0) ? 4 : 1;
        if (cur_rst()) begin
            k = 0;
        end else begin
            rdy_before = !pend_full;
            k++;
            if ((k % (2 * d) == 0) && (((k / (2 * d)) - 1) % 64 == 0)) begin
                fw.push_back(pend_full ? pend : 64'h0);
                fur.push_back(!pend_full);
                pend_full = 1'b0;
            end
            if (valid && rdy_before) begin
                pend = {left, right};
                pend_full = 1'b1;
                if (sel == 0) acc_q.push_back(pend);
            end
        end
    endtask

    task automatic compare();
        int d, m, b, f;
        logic [63:0] w;
        logic e_bclk, e_fclk, e_data, e_fs, e_ur, e_rdy;
        d = (sel != 0) ? 4 : 1;
        e_bclk = 1'b0; e_fclk = 1'b0; e_data = 1'b0;
        e_fs = 1'b0; e_ur = 1'b0; e_rdy = 1'b1;
        if (!cur_rst()) begin
            e_bclk = ((k / d) % 2) == 1;
            e_rdy  = !pend_full;
            m = k / (2 * d);
            if (m > 0) begin
                b = (m - 1) % 64;
                f = (m - 1) / 64;
                w = fw[f];
                e_fclk = (b >= 32);
                e_data = w[63 - b];
                e_fs   = (k % (2 * d) == 0) && (b == 0);
                e_ur   = e_fs && fur[f];
            end
        end
        chk("cyc_bclk", o_bclk, e_bclk);
        chk("cyc_fclk", o_fclk, e_fclk);
        chk("cyc_data", o_data, e_data);
        chk("cyc_frame_start", o_fs, e_fs);
        chk("cyc_underrun", o_ur, e_ur);
        chk("cyc_ready", o_rdy, e_rdy);
        // receiver: sample data on each rising bclk, frame aligned by frame_start
        if (sel == 0 && !cur_rst()) begin
            if (o_fs) begin
                rx_on = 1'b1;
                rx_n = 0;
                rx_ur = o_ur;
            end else if (o_bclk && !prev_bclk && rx_on) begin
                rx = {rx[62:0], o_data};
                rx_n++;
                if (rx_n == 64) begin
                    if (!rx_ur) rx_q.push_back(rx);
                    rx_on = 1'b0;
                end
            end
            prev_bclk = o_bclk;
        end
    endtask

    task automatic tick();
        logic rdy_before;
        rdy_before = o_rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
        if (rand_data && rdy_before && valid) begin
            left = $urandom;
            right = $urandom;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic wait_fs(input int budget, output bit ok, output int cnt);
        ok = 1'b0;
        cnt = 0;
        while (!ok && cnt < budget) begin
            tick();
            cnt++;
            if (o_fs) ok = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        sel = 0;
        // reset held with a pair offered
        valid = 1'b1;
        left = 32'h12345678;
        right = 32'h9ABCDEF0;
        run(5);
        chk("rst_ready", ifa.sample_ready, 1'b1);
        chk("rst_bclk", a_bclk, 1'b0);
        chk("rst_pulses", {a_fs, a_ur}, 2'b00);

        // single frame
        rst_a = 1'b0;
        tick();
        valid = 1'b0;
        chk("first_bclk_rise", a_bclk, 1'b1);
        tick();
        chk("first_frame_start", a_fs, 1'b1);
        chk("first_underrun", a_ur, 1'b0);
        fs_cnt = 0; ur_cnt = 0;
        for (int i = 0; i < 127; i++) begin
            tick();
            if (a_fs) fs_cnt++;
            if (a_ur) ur_cnt++;
        end
        chk("single_fs_count", fs_cnt, 0);
        chk("single_ur_count", ur_cnt, 0);
        chk("single_rx_count", rx_q.size(), 1);
        chk("single_rx_pair", rx_q[0], 64'h12345678_9ABCDEF0);
        run(200);

        // streaming
        wait_fs(300, found, n);
        chk("stream_align", found, 1'b1);
        base = acc_q.size();
        n = 0; ur_cnt = 0; rises = 0; last_rise = -1;
        prev_rdy = o_rdy;
        rand_data = 1'b1;
        left = $urandom; right = $urandom;
        valid = 1'b1;
        while ((acc_q.size() - base) < 200 && n < 30000) begin
            tick();
            n++;
            if (a_ur) ur_cnt++;
            if (o_rdy && !prev_rdy) begin
                rises++;
                if (last_rise >= 0) chk("ready_period", n - last_rise, 128);
                last_rise = n;
            end
            prev_rdy = o_rdy;
        end
        valid = 1'b0;
        rand_data = 1'b0;
        chk("stream_count", acc_q.size() - base, 200);
        chk("stream_underrun", ur_cnt, 0);
        chk("stream_ready_rises", rises, 199);

        // underrun: three empty frames, then one pair
        run(256);
        wait_fs(300, found, n);
        chk("ur_align", found, 1'b1);
        ur_cnt = a_ur ? 1 : 0;
        pair = 64'hA5A50F0F_C3C37E81;
        for (int i = 1; i < 384; i++) begin
            if (i == 300) begin
                valid = 1'b1;
                left = pair[63:32];
                right = pair[31:0];
            end
            if (i == 301) valid = 1'b0;
            tick();
            if (a_ur) ur_cnt++;
        end
        chk("ur_three_frames", ur_cnt, 3);
        ur_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            if (a_ur) ur_cnt++;
        end
        chk("ur_pair_frame_clean", ur_cnt, 0);
        run(140);
        chk("ur_pair_data", rx_q[rx_q.size() - 1], pair);

        // valid raised in the exact frame-boundary clock
        run(256);
        n = 0;
        while (((k + 1) % 128) != 2 && n < 300) begin
            tick();
            n++;
        end
        chk("coll_align", ((k + 1) % 128), 2);
        pair = 64'h0BADF00D_13572468;
        valid = 1'b1;
        left = pair[63:32];
        right = pair[31:0];
        tick();
        valid = 1'b0;
        chk("coll_underrun", a_ur, 1'b1);
        chk("coll_buffer_filled", ifa.sample_ready, 1'b0);
        run(128 + 140);
        chk("coll_pair_next_frame", rx_q[rx_q.size() - 1], pair);

        run(300);
        chk("rx_total", rx_q.size(), acc_q.size());
        for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
            chk("rx_order", rx_q[i], acc_q[i]);

        // BCLK_DIV=4 instance
        rst_a = 1'b1;
        sel = 1;
        model_reset();
        rand_data = 1'b1;
        left = $urandom; right = $urandom;
        valid = 1'b1;
        rst_b = 1'b0;
        n = 0; r1 = -1; r2 = -1;
        prev_b = o_bclk;
        while (r2 < 0 && n < 100) begin
            tick();
            n++;
            if (o_bclk && !prev_b) begin
                if (r1 < 0) r1 = n;
                else r2 = n;
            end
            prev_b = o_bclk;
        end
        chk("b_first_rise", r1, 4);
        chk("b_bclk_period", r2 - r1, 8);
        wait_fs(600, found, n);
        chk("b_fs_found", found, 1'b1);
        wait_fs(600, found, n);
        chk("b_frame_len", n, 512);
        run(320);
        chk("b_bit40_fclk", o_fclk, 1'b1);
        rst_b = 1'b1;
        #1;
        chk("b_rst_bclk", b_bclk, 1'b0);
        chk("b_rst_fclk", b_fclk, 1'b0);
        chk("b_rst_data", b_data, 1'b0);
        chk("b_rst_pulses", {b_fs, b_ur}, 2'b00);
        chk("b_rst_ready", ifb.sample_ready, 1'b1);
        model_reset();
        run(2);
        rst_b = 1'b0;
        wait_fs(20, found, n);
        chk("b_restart_found", found, 1'b1);
        chk("b_restart_delay", n, 8);
        run(600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
